// File: rtl/ghostbus_pkg.sv
// Shared ghostbus definitions: arbiter FSM states, default bus widths, index sizing.
package ghostbus_pkg;

  localparam int unsigned GB_AW = 12;
  localparam int unsigned GB_DW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRwait,
    StDone
  } gb_state_e;

  // Bits needed to index n items; never less than one so vectors stay legal for n == 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request at or after rr_ptr, wrapping.
module rr_pick
  import ghostbus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdxW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] rr_ptr,
  output logic [IdxW-1:0] grant,
  output logic            valid
);

  logic [IdxW-1:0] slot;

  // Walk NREQ slots starting at rr_ptr; the first hit wins and later hits are ignored.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    slot  = rr_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!valid && req[slot]) begin
        valid = 1'b1;
        grant = slot;
      end
      slot = (slot == IdxW'(NREQ - 1)) ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/ghostbus_arbiter.sv
// Round-robin arbiter sharing one ghostbus host port between NREQ requesters,
// one transaction in flight at a time.
module ghostbus_arbiter
  import ghostbus_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = GB_AW,
  parameter int unsigned DW     = GB_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               gb_clk,
  input  logic               gb_rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      gb_addr,
  output logic [DW-1:0]      gb_dout,
  output logic               gb_we,
  input  logic [DW-1:0]      gb_din
);

  localparam int unsigned IdxW = idx_width(NREQ);
  // Counter only ever holds RD_LAT-1 down to 0.
  localparam int unsigned CntW = idx_width(RD_LAT);

  gb_state_e       state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   gb_addr_q;
  logic [DW-1:0]   gb_dout_q;
  logic            gb_we_q;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_idx),
    .valid  (pick_valid)
  );

  // Transaction FSM; outputs are registered on entry to the state they belong to, so
  // gb_we is high during ISSUE and ack is high during DONE.
  always_ff @(posedge gb_clk) begin
    if (!gb_rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      gb_addr_q <= '0;
      gb_dout_q <= '0;
      gb_we_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q   <= pick_idx;
            we_q      <= req_we[pick_idx];
            gb_addr_q <= req_addr[pick_idx*AW +: AW];
            gb_dout_q <= req_wdata[pick_idx*DW +: DW];
            gb_we_q   <= req_we[pick_idx];
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          gb_we_q <= 1'b0;
          if (we_q) begin
            ack_q[grant_q] <= 1'b1;
            state_q        <= StDone;
          end else begin
            cnt_q   <= CntW'(RD_LAT - 1);
            state_q <= StRwait;
          end
        end
        StRwait: begin
          if (cnt_q == '0) begin
            rdata_q        <= gb_din;
            ack_q[grant_q] <= 1'b1;
            state_q        <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          ack_q    <= '0;
          rr_ptr_q <= (grant_q == IdxW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign gb_addr = gb_addr_q;
  assign gb_dout = gb_dout_q;
  assign gb_we   = gb_we_q;

endmodule
